// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, one-entry decode buffer, PC+4 write-back.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ILEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    output logic            pc_if_write_en,
    output logic [XLEN-1:0] pc_if_write,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [ILEN-1:0] inst_data_q, inst_data_d;
    logic            discard_q, discard_d;
    logic            misalign;
    logic            resp_keep;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fault_q, fault_d;
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A response is only usable if nothing redirected the PC since the request went out.
    assign resp_keep = imem_resp_valid && !discard_q && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (misalign) begin
                    if (!redirect) begin
                        state_d = S_FULL;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = resp_keep ? S_FULL : S_REQ;
                end
            end
            S_FULL: begin
                if (redirect || inst_ready) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // pc_if_write is derived from registered state only, so the register block sees no loop.
    always_comb begin
        imem_req_valid = 1'b0;
        pc_if_write_en = 1'b0;
        pc_if_write    = '0;
        if (!rst) begin
            imem_req_valid = (state_q == S_REQ) && !misalign;
            pc_if_write_en = (state_q == S_WAIT) && resp_keep;
            if (state_q == S_WAIT) begin
                pc_if_write = req_pc_q + XLEN'(PC_STEP);
            end
        end
    end

    assign imem_req_addr = pc;
    assign inst_valid    = (state_q == S_FULL);
    assign inst_data     = inst_data_q;
    assign inst_pc       = inst_pc_q;

    always_comb begin
        req_pc_d    = req_pc_q;
        inst_pc_d   = inst_pc_q;
        inst_data_d = inst_data_q;
        discard_d   = discard_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d     = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                if (misalign) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (!redirect) begin
                        inst_data_d = '0;
                        inst_pc_d   = pc;
                        fault_d     = 1'b1;
                    end
`endif
                end else if (imem_req_ready) begin
                    req_pc_d  = pc;
                    discard_d = redirect;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    discard_d = 1'b0;
                    if (resp_keep) begin
                        inst_data_d = imem_resp_data;
                        inst_pc_d   = req_pc_q;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            S_FULL: begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect || inst_ready) begin
                    fault_d = 1'b0;
                end
`endif
            end
            default: begin
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc_q    <= '0;
            inst_pc_q   <= '0;
            inst_data_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            req_pc_q    <= req_pc_d;
            inst_pc_q   <= inst_pc_d;
            inst_data_q <= inst_data_d;
            discard_q   <= discard_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign inst_fault = fault_q;
`else
    assign inst_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences, randomized run vs model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [63:0] pc;
    logic        redirect;
    logic        pc_if_write_en;
    logic [63:0] pc_if_write;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_fault;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.XLEN(64), .ILEN(32), .PC_STEP(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .redirect        (redirect),
        .pc_if_write_en  (pc_if_write_en),
        .pc_if_write     (pc_if_write),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        redir;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ir;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_we;
        logic [63:0] e_pcw;
        logic        e_iv;
        logic [63:0] e_ipc;
        logic [31:0] e_idata;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic [63:0] p, input logic rd, input logic rdy, input logic rv,
                                input logic [31:0] dat, input logic ir, input logic e_req,
                                input logic [63:0] e_addr, input logic e_we, input logic [63:0] e_pcw,
                                input logic e_iv, input logic [63:0] e_ipc, input logic [31:0] e_idata);
        vec_t v;
        v.pc = p; v.redir = rd; v.rdy = rdy; v.rv = rv; v.rdata = dat; v.ir = ir;
        v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_pcw = e_pcw;
        v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_idata = e_idata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] p, input logic rd, input logic rdy, input logic rv,
                         input logic [31:0] dat, input logic ir);
        pc = p; redirect = rd; imem_req_ready = rdy; imem_resp_valid = rv;
        imem_resp_data = dat; inst_ready = ir;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst pc_we", 64'(pc_if_write_en), 64'h0);
        chk("rst pc_write", pc_if_write, 64'h0);
        chk("rst inst_valid", 64'(inst_valid), 64'h0);
        chk("rst inst_fault", 64'(inst_fault), 64'h0);
        chk("rst inst_data", 64'(inst_data), 64'h0);
        chk("rst inst_pc", inst_pc, 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    initial begin
        logic        outst;
        logic [63:0] oaddr;
        int          resp_cyc;
        logic [63:0] pc_nxt;
        logic [63:0] exp_pc;
        logic [63:0] tgt;
        int          hs;
        int          idle;
        string       nm;

        rst = 1'b1;
        drive(64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        tbl[0]  = mk(64'h0,   0, 1, 0, 32'h0,        0, 1, 64'h0,   0, 64'h0,   0, 64'h0,   32'h0);
        tbl[1]  = mk(64'h0,   0, 1, 1, 32'h13,       0, 0, 64'h0,   1, 64'h4,   0, 64'h0,   32'h0);
        tbl[2]  = mk(64'h4,   0, 1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h0,   1, 64'h0,   32'h13);
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = tbl[2];
        tbl[7]  = mk(64'h4,   0, 1, 0, 32'h0,        1, 0, 64'h0,   0, 64'h0,   1, 64'h0,   32'h13);
        tbl[8]  = mk(64'h4,   0, 1, 0, 32'h0,        0, 1, 64'h4,   0, 64'h0,   0, 64'h0,   32'h0);
        tbl[9]  = mk(64'h4,   0, 1, 1, 32'h0010_0093, 0, 0, 64'h0,  1, 64'h8,   0, 64'h0,   32'h0);
        tbl[10] = mk(64'h8,   0, 1, 0, 32'h0,        1, 0, 64'h0,   0, 64'h0,   1, 64'h4,   32'h0010_0093);
        tbl[11] = mk(64'h8,   0, 1, 0, 32'h0,        0, 1, 64'h8,   0, 64'h0,   0, 64'h0,   32'h0);
        tbl[12] = mk(64'h8,   1, 1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   32'h0);
        tbl[13] = mk(64'h100, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 64'h0,  0, 64'h0,   0, 64'h0,   32'h0);
        tbl[14] = mk(64'h100, 0, 1, 0, 32'h0,        0, 1, 64'h100, 0, 64'h0,   0, 64'h0,   32'h0);
        tbl[15] = mk(64'h100, 0, 1, 1, 32'h11,       0, 0, 64'h0,   1, 64'h104, 0, 64'h0,   32'h0);
        tbl[16] = mk(64'h104, 0, 1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h0,   1, 64'h100, 32'h11);
        tbl[17] = mk(64'h104, 1, 1, 0, 32'h0,        0, 0, 64'h0,   0, 64'h0,   1, 64'h100, 32'h11);
        tbl[18] = mk(64'h200, 0, 0, 0, 32'h0,        0, 1, 64'h200, 0, 64'h0,   0, 64'h0,   32'h0);
        tbl[19] = mk(64'h200, 0, 1, 0, 32'h0,        0, 1, 64'h200, 0, 64'h0,   0, 64'h0,   32'h0);
        tbl[20] = mk(64'h200, 0, 1, 1, 32'h22,       0, 0, 64'h0,   1, 64'h204, 0, 64'h0,   32'h0);
        tbl[21] = mk(64'h204, 0, 1, 0, 32'h0,        1, 0, 64'h0,   0, 64'h0,   1, 64'h200, 32'h22);
        tbl[22] = mk(64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0, 32'h0);
        tbl[23] = mk(64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 32'h33, 0, 0, 64'h0, 1, 64'h0, 0, 64'h0, 32'h0);
        tbl[24] = mk(64'h0,   0, 1, 0, 32'h0,        1, 0, 64'h0,   0, 64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33);

        do_reset();

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tbl[i].pc, tbl[i].redir, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].ir);
            #1;
            nm = $sformatf("row%0d", i);
            chk({nm, " req_valid"}, 64'(imem_req_valid), 64'(tbl[i].e_req));
            chk({nm, " pc_we"}, 64'(pc_if_write_en), 64'(tbl[i].e_we));
            chk({nm, " inst_valid"}, 64'(inst_valid), 64'(tbl[i].e_iv));
            chk({nm, " inst_fault"}, 64'(inst_fault), 64'h0);
            if (tbl[i].e_req) chk({nm, " req_addr"}, imem_req_addr, tbl[i].e_addr);
            if (tbl[i].e_we)  chk({nm, " pc_write"}, pc_if_write, tbl[i].e_pcw);
            if (tbl[i].e_iv) begin
                chk({nm, " inst_pc"}, inst_pc, tbl[i].e_ipc);
                chk({nm, " inst_data"}, 64'(inst_data), 64'(tbl[i].e_idata));
            end
        end

        // Misaligned PC handling
`ifdef FETCH_MISALIGN_CHECK_EN
        @(negedge clk); drive(64'h2, 0, 1, 0, 32'h0, 0); #1;
        chk("mis no_req", 64'(imem_req_valid), 64'h0);
        @(negedge clk); drive(64'h2, 0, 1, 0, 32'h0, 0); #1;
        chk("mis iv", 64'(inst_valid), 64'h1);
        chk("mis fault", 64'(inst_fault), 64'h1);
        chk("mis ipc", inst_pc, 64'h2);
        chk("mis idata", 64'(inst_data), 64'h0);
        chk("mis no_req2", 64'(imem_req_valid), 64'h0);
        chk("mis no_we", 64'(pc_if_write_en), 64'h0);
        @(negedge clk); drive(64'h2, 1, 0, 0, 32'h0, 0); #1;
        chk("mis hold", 64'(inst_fault), 64'h1);
        @(negedge clk); drive(64'h8, 0, 0, 0, 32'h0, 0); #1;
        chk("mis flushed iv", 64'(inst_valid), 64'h0);
        chk("mis fault clr", 64'(inst_fault), 64'h0);
        chk("mis new req", 64'(imem_req_valid), 64'h1);
        chk("mis new addr", imem_req_addr, 64'h8);
`else
        @(negedge clk); drive(64'h2, 0, 1, 0, 32'h0, 0); #1;
        chk("mis req", 64'(imem_req_valid), 64'h1);
        chk("mis addr", imem_req_addr, 64'h2);
        chk("mis fault", 64'(inst_fault), 64'h0);
        @(negedge clk); drive(64'h2, 0, 1, 1, 32'h44, 0); #1;
        chk("mis we", 64'(pc_if_write_en), 64'h1);
        chk("mis pcw", pc_if_write, 64'h6);
        @(negedge clk); drive(64'h6, 0, 1, 0, 32'h0, 1); #1;
        chk("mis iv", 64'(inst_valid), 64'h1);
        chk("mis ipc", inst_pc, 64'h2);
        chk("mis fault2", 64'(inst_fault), 64'h0);
`endif

        // Reset while a request is outstanding
        do_reset();
        @(negedge clk); drive(64'h40, 0, 1, 0, 32'h0, 0); #1;
        chk("mrst req", 64'(imem_req_valid), 64'h1);
        @(negedge clk); rst = 1'b1; drive(64'h40, 0, 0, 0, 32'h0, 0); #1;
        chk("mrst req_off", 64'(imem_req_valid), 64'h0);
        chk("mrst we_off", 64'(pc_if_write_en), 64'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive(64'h40, 0, 1, 0, 32'h0, 0); #1;
        chk("mrst re-req", 64'(imem_req_valid), 64'h1);
        chk("mrst addr", imem_req_addr, 64'h40);
        @(negedge clk); drive(64'h40, 0, 1, 1, 32'h55, 0); #1;
        chk("mrst we", 64'(pc_if_write_en), 64'h1);
        chk("mrst pcw", pc_if_write, 64'h44);
        @(negedge clk); drive(64'h44, 0, 1, 0, 32'h0, 1); #1;
        chk("mrst ipc", inst_pc, 64'h40);
        chk("mrst idata", 64'(inst_data), 64'h55);

        // Randomized run with register-block and memory models
        do_reset();
        outst = 1'b0; oaddr = '0; resp_cyc = 0;
        pc_nxt = '0; exp_pc = '0; hs = 0; idle = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            pc = pc_nxt;
            redirect = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            else tgt = {32'($urandom), 32'($urandom)} & ~64'h3;
            imem_req_ready  = ($urandom_range(0, 2) != 0);
            inst_ready      = 1'($urandom_range(0, 1));
            imem_resp_valid = outst && (cyc == resp_cyc);
            imem_resp_data  = imem_resp_valid ? mem_word(oaddr) : 32'($urandom);
            #1;
            if (imem_req_valid) begin
                chk("rnd single_outstanding", 64'(outst), 64'h0);
                chk("rnd req_addr", imem_req_addr, pc);
            end
            if (imem_resp_valid) outst = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                outst = 1'b1; oaddr = imem_req_addr;
                resp_cyc = cyc + $urandom_range(1, 3);
            end
            pc_nxt = pc;
            if (pc_if_write_en) begin
                chk("rnd we_vs_redirect", 64'(redirect), 64'h0);
                chk("rnd pc_write", pc_if_write, pc + 64'd4);
                pc_nxt = pc_if_write;
            end
            idle++;
            if (redirect) begin
                pc_nxt = tgt; exp_pc = tgt; idle = 0;
            end else if (inst_valid && inst_ready) begin
                chk("rnd inst_pc", inst_pc, exp_pc);
                chk("rnd inst_data", 64'(inst_data), 64'(mem_word(exp_pc)));
                chk("rnd inst_fault", 64'(inst_fault), 64'h0);
                exp_pc = exp_pc + 64'd4;
                hs++; idle = 0;
            end
            if (idle > 64) begin
                chk("rnd progress_timeout", 64'(idle), 64'd64);
                break;
            end
        end
        checks++;
        if (hs < 100) begin
            errors++;
            $display("FAIL rnd delivered: got %0d instructions, expected at least 100", hs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
